// File: rtl/id_pipe.sv
// id_pipe: MIPS instruction decode with operand forwarding, load-use stall detection
// and a registered ID/EX boundary with flush/stall control and a saturating stall counter.
module id_pipe #(
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pc_i,
    input  logic [31:0]               inst_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic [NUM_FWD-1:0]        fwd_wreg_i,
    input  logic [5*NUM_FWD-1:0]      fwd_wd_i,
    input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata_i,
    input  logic                      ex_is_load_i,
    input  logic [DATA_W-1:0]         reg1_data_i,
    input  logic [DATA_W-1:0]         reg2_data_i,
    output logic                      reg1_read_o,
    output logic                      reg2_read_o,
    output logic [4:0]                reg1_addr_o,
    output logic [4:0]                reg2_addr_o,
    output logic                      stallreq_o,
    output logic [31:0]               ex_pc_o,
    output logic [7:0]                ex_aluop_o,
    output logic [2:0]                ex_alusel_o,
    output logic [DATA_W-1:0]         ex_reg1_o,
    output logic [DATA_W-1:0]         ex_reg2_o,
    output logic [4:0]                ex_wd_o,
    output logic                      ex_wreg_o,
    output logic                      ex_inv_inst_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);
    localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_ORI = 6'b001101, OP_ANDI = 6'b001100,
        OP_XORI = 6'b001110, OP_LUI = 6'b001111, OP_PREF = 6'b110011, OP_SLTI = 6'b001010,
        OP_SLTIU = 6'b001011, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
    localparam logic [5:0] FN_OR = 6'b100101, FN_AND = 6'b100100, FN_XOR = 6'b100110,
        FN_NOR = 6'b100111, FN_SLLV = 6'b000100, FN_SRLV = 6'b000110, FN_SRAV = 6'b000111,
        FN_SYNC = 6'b001111, FN_SLT = 6'b101010, FN_SLTU = 6'b101011, FN_ADD = 6'b100000,
        FN_SUB = 6'b100010, FN_SLL = 6'b000000, FN_SRL = 6'b000010, FN_SRA = 6'b000011;
    localparam logic [7:0] EXE_NOP_OP = 8'h00, EXE_AND_OP = 8'b00100100, EXE_OR_OP = 8'b00100101,
        EXE_XOR_OP = 8'b00100110, EXE_NOR_OP = 8'b00100111, EXE_SLL_OP = 8'b01111100,
        EXE_SRL_OP = 8'b00000010, EXE_SRA_OP = 8'b00000011, EXE_SLT_OP = 8'b00101010,
        EXE_SLTU_OP = 8'b00101011, EXE_ADD_OP = 8'b00100000, EXE_SUB_OP = 8'b00100010,
        EXE_ADDI_OP = 8'b01010101, EXE_LW_OP = 8'b11100011;
    localparam logic [2:0] EXE_RES_NOP = 3'b000, EXE_RES_LOGIC = 3'b001, EXE_RES_SHIFT = 3'b010,
        EXE_RES_ARITHMETIC = 3'b100, EXE_RES_LOAD_STORE = 3'b111;
    typedef struct packed {
        logic [7:0] aluop;
        logic [2:0] alusel;
        logic       rd1;
        logic       rd2;
        logic       wreg;
        logic       valid;
    } dec_t;
    typedef struct packed {
        logic [31:0]       pc;
        logic [7:0]        aluop;
        logic [2:0]        alusel;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
        logic [4:0]        wd;
        logic              wreg;
        logic              inv;
    } idex_t;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sa, wd;
    logic [DATA_W-1:0] imm, op1, op2;
    logic [31:0] lui_imm;
    dec_t d;
    idex_t ex, nxt;
    assign op = inst_i[31:26];
    assign rs = inst_i[25:21];
    assign rt = inst_i[20:16];
    assign rd = inst_i[15:11];
    assign sa = inst_i[10:6];
    assign fn = inst_i[5:0];
    assign lui_imm = {inst_i[15:0], 16'h0000};
    always_comb begin
        d   = '{EXE_NOP_OP, EXE_RES_NOP, 1'b0, 1'b0, 1'b0, 1'b0};
        wd  = rd;
        imm = '0;
        case (op)
            OP_SPECIAL: if (sa == 5'd0) case (fn)
                FN_OR:   d = '{EXE_OR_OP,   EXE_RES_LOGIC,      1'b1, 1'b1, 1'b1, 1'b1};
                FN_AND:  d = '{EXE_AND_OP,  EXE_RES_LOGIC,      1'b1, 1'b1, 1'b1, 1'b1};
                FN_XOR:  d = '{EXE_XOR_OP,  EXE_RES_LOGIC,      1'b1, 1'b1, 1'b1, 1'b1};
                FN_NOR:  d = '{EXE_NOR_OP,  EXE_RES_LOGIC,      1'b1, 1'b1, 1'b1, 1'b1};
                FN_SLLV: d = '{EXE_SLL_OP,  EXE_RES_SHIFT,      1'b1, 1'b1, 1'b1, 1'b1};
                FN_SRLV: d = '{EXE_SRL_OP,  EXE_RES_SHIFT,      1'b1, 1'b1, 1'b1, 1'b1};
                FN_SRAV: d = '{EXE_SRA_OP,  EXE_RES_SHIFT,      1'b1, 1'b1, 1'b1, 1'b1};
                FN_SYNC: d = '{EXE_NOP_OP,  EXE_RES_NOP,        1'b0, 1'b1, 1'b0, 1'b1};
                FN_SLT:  d = '{EXE_SLT_OP,  EXE_RES_ARITHMETIC, 1'b1, 1'b1, 1'b1, 1'b1};
                FN_SLTU: d = '{EXE_SLTU_OP, EXE_RES_ARITHMETIC, 1'b1, 1'b1, 1'b1, 1'b1};
                FN_ADD:  d = '{EXE_ADD_OP,  EXE_RES_ARITHMETIC, 1'b1, 1'b1, 1'b1, 1'b1};
                FN_SUB:  d = '{EXE_SUB_OP,  EXE_RES_ARITHMETIC, 1'b1, 1'b1, 1'b1, 1'b1};
                default: ;
            endcase
            OP_ORI:   begin d = '{EXE_OR_OP,   EXE_RES_LOGIC,      1'b1, 1'b0, 1'b1, 1'b1}; wd = rt; imm = DATA_W'(inst_i[15:0]); end
            OP_ANDI:  begin d = '{EXE_AND_OP,  EXE_RES_LOGIC,      1'b1, 1'b0, 1'b1, 1'b1}; wd = rt; imm = DATA_W'(inst_i[15:0]); end
            OP_XORI:  begin d = '{EXE_XOR_OP,  EXE_RES_LOGIC,      1'b1, 1'b0, 1'b1, 1'b1}; wd = rt; imm = DATA_W'(inst_i[15:0]); end
            OP_LUI:   begin d = '{EXE_OR_OP,   EXE_RES_LOGIC,      1'b1, 1'b0, 1'b1, 1'b1}; wd = rt; imm = DATA_W'($signed(lui_imm)); end
            OP_PREF:  d = '{EXE_NOP_OP, EXE_RES_NOP, 1'b0, 1'b0, 1'b0, 1'b1};
            OP_SLTI:  begin d = '{EXE_SLT_OP,  EXE_RES_ARITHMETIC, 1'b1, 1'b0, 1'b1, 1'b1}; wd = rt; imm = DATA_W'($signed(inst_i[15:0])); end
            OP_SLTIU: begin d = '{EXE_SLTU_OP, EXE_RES_ARITHMETIC, 1'b1, 1'b0, 1'b1, 1'b1}; wd = rt; imm = DATA_W'($signed(inst_i[15:0])); end
            OP_ADDI:  begin d = '{EXE_ADDI_OP, EXE_RES_ARITHMETIC, 1'b1, 1'b0, 1'b1, 1'b1}; wd = rt; imm = DATA_W'($signed(inst_i[15:0])); end
            OP_LW:    begin d = '{EXE_LW_OP,   EXE_RES_LOAD_STORE, 1'b1, 1'b0, 1'b1, 1'b1}; wd = rt; imm = DATA_W'($signed(inst_i[15:0])); end
            default: ;
        endcase
        // Immediate shifts live in SPECIAL but carry a shamt, so they bypass the sa==0 gate above
        if (inst_i[31:21] == 11'd0) case (fn)
            FN_SLL: begin d = '{EXE_SLL_OP, EXE_RES_SHIFT, 1'b0, 1'b1, 1'b1, 1'b1}; imm = DATA_W'(sa); end
            FN_SRL: begin d = '{EXE_SRL_OP, EXE_RES_SHIFT, 1'b0, 1'b1, 1'b1, 1'b1}; imm = DATA_W'(sa); end
            FN_SRA: begin d = '{EXE_SRA_OP, EXE_RES_SHIFT, 1'b0, 1'b1, 1'b1, 1'b1}; imm = DATA_W'(sa); end
            default: ;
        endcase
    end
    // Scan oldest to youngest so the lowest-index (youngest) matching slot wins
    function automatic logic [DATA_W-1:0] pick(input logic rdx, input logic [4:0] a, input logic [DATA_W-1:0] rf);
        logic [DATA_W-1:0] r;
        r = rf;
        for (int k = NUM_FWD - 1; k >= 0; k--)
            if (fwd_wreg_i[k] && fwd_wd_i[5*k +: 5] == a) r = fwd_wdata_i[DATA_W*k +: DATA_W];
        return !rdx ? imm : (a == 5'd0) ? '0 : r;
    endfunction
    always_comb begin
        op1 = pick(d.rd1, rs, reg1_data_i);
        op2 = pick(d.rd2, rt, reg2_data_i);
    end
    assign reg1_read_o = rst ? 1'b0 : d.rd1;
    assign reg2_read_o = rst ? 1'b0 : d.rd2;
    assign reg1_addr_o = rst ? 5'd0 : rs;
    assign reg2_addr_o = rst ? 5'd0 : rt;
    assign stallreq_o = ex_is_load_i && fwd_wreg_i[0] && fwd_wd_i[4:0] != 5'd0 &&
        ((reg1_read_o && reg1_addr_o == fwd_wd_i[4:0]) || (reg2_read_o && reg2_addr_o == fwd_wd_i[4:0]));
    assign nxt = '{pc_i, d.valid ? d.aluop : EXE_NOP_OP, d.valid ? d.alusel : EXE_RES_NOP,
        op1, op2, wd, d.valid && d.wreg, !d.valid};
    always_ff @(posedge clk) begin
        if (rst) begin
            ex          <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (stallreq_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush_i || (!stall_i && stallreq_o)) ex <= '0;
            else if (!stall_i) ex <= nxt;
        end
    end
    assign ex_pc_o       = ex.pc;
    assign ex_aluop_o    = ex.aluop;
    assign ex_alusel_o   = ex.alusel;
    assign ex_reg1_o     = ex.r1;
    assign ex_reg2_o     = ex.r2;
    assign ex_wd_o       = ex.wd;
    assign ex_wreg_o     = ex.wreg;
    assign ex_inv_inst_o = ex.inv;
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed checks of decode, forwarding, load-use stall, flush/stall priority,
// counter saturation and reset for id_pipe built with 64-bit data and a 2-bit stall counter.
module tb_id_pipe;
    logic clk = 0, rst = 1;
    logic [31:0] pc_i = 0, inst_i = 0;
    logic stall_i = 0, flush_i = 0, ex_is_load_i = 0;
    logic [1:0] fwd_wreg_i = 0;
    logic [9:0] fwd_wd_i = 0;
    logic [127:0] fwd_wdata_i = 0;
    logic [63:0] reg1_data_i = 0, reg2_data_i = 0;
    logic reg1_read_o, reg2_read_o, stallreq_o, ex_wreg_o, ex_inv_inst_o;
    logic [4:0] reg1_addr_o, reg2_addr_o, ex_wd_o;
    logic [31:0] ex_pc_o;
    logic [7:0] ex_aluop_o;
    logic [2:0] ex_alusel_o;
    logic [63:0] ex_reg1_o, ex_reg2_o;
    logic [1:0] stall_cnt_o;
    int n_tests = 0, n_fail = 0;

    id_pipe #(.DATA_W(64), .NUM_FWD(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .stall_i(stall_i), .flush_i(flush_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
        .ex_is_load_i(ex_is_load_i), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o), .reg1_addr_o(reg1_addr_o),
        .reg2_addr_o(reg2_addr_o), .stallreq_o(stallreq_o), .ex_pc_o(ex_pc_o),
        .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o), .ex_reg1_o(ex_reg1_o),
        .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
        .ex_inv_inst_o(ex_inv_inst_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ORI  = 32'h34028000, I_ADDI = 32'h2003FFFF, I_LUI = 32'h3C048000,
        I_OR = 32'h00212825, I_ADD = 32'h00E94020, I_SLL = 32'h00023100, I_LW = 32'h8C2AFFFC,
        I_BAD = 32'hFCE00000;

    initial begin
        inst_i = I_ADD; ex_is_load_i = 1; fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd7};
        #1;
        check("rst_read1", reg1_read_o, 0);
        check("rst_addr2", reg2_addr_o, 0);
        check("rst_stallreq", stallreq_o, 0);
        step(); step();
        check("rst_wreg", ex_wreg_o, 0);
        check("rst_cnt", stall_cnt_o, 0);
        check("rst_aluop", ex_aluop_o, 0);
        rst = 0; ex_is_load_i = 0; fwd_wreg_i = 0; fwd_wd_i = 0;
        inst_i = I_ORI; pc_i = 32'h100;
        #1;
        check("ori_read1", reg1_read_o, 1);
        check("ori_read2", reg2_read_o, 0);
        step();
        check("ori_imm", ex_reg2_o, 64'h8000);
        check("ori_rs0", ex_reg1_o, 0);
        check("ori_wd", ex_wd_o, 2);
        check("ori_wreg", ex_wreg_o, 1);
        check("ori_aluop", ex_aluop_o, 8'h25);
        check("ori_alusel", ex_alusel_o, 3'd1);
        check("ori_pc", ex_pc_o, 32'h100);
        inst_i = I_ADDI; step();
        check("addi_imm", ex_reg2_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_aluop", ex_aluop_o, 8'h55);
        inst_i = I_LUI; step();
        check("lui_imm", ex_reg2_o, 64'hFFFF_FFFF_8000_0000);
        check("lui_wd", ex_wd_o, 4);
        inst_i = I_OR; reg1_data_i = 64'hAAAA; reg2_data_i = 64'hBBBB;
        fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_wdata_i = {64'h2222, 64'h1111};
        step();
        check("fwd_pri_r1", ex_reg1_o, 64'h1111);
        check("fwd_pri_r2", ex_reg2_o, 64'h1111);
        check("or_wd", ex_wd_o, 5);
        fwd_wd_i = {5'd0, 5'd0}; step();
        check("fwd_none_r1", ex_reg1_o, 64'hAAAA);
        check("fwd_none_r2", ex_reg2_o, 64'hBBBB);
        fwd_wd_i = {5'd1, 5'd3}; step();
        check("fwd_slot1", ex_reg1_o, 64'h2222);
        fwd_wreg_i = 0; inst_i = I_SLL; step();
        check("sll_shamt", ex_reg1_o, 4);
        check("sll_rt", ex_reg2_o, 64'hBBBB);
        check("sll_aluop", ex_aluop_o, 8'h7C);
        check("sll_wd", ex_wd_o, 6);
        inst_i = I_LW; step();
        check("lw_off", ex_reg2_o, 64'hFFFF_FFFF_FFFF_FFFC);
        check("lw_aluop", ex_aluop_o, 8'hE3);
        check("lw_alusel", ex_alusel_o, 3'd7);
        check("lw_wd", ex_wd_o, 10);
        inst_i = I_BAD; ex_is_load_i = 1; fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd7};
        #1;
        check("bad_nohaz", stallreq_o, 0);
        step();
        check("bad_inv", ex_inv_inst_o, 1);
        check("bad_wreg", ex_wreg_o, 0);
        check("bad_aluop", ex_aluop_o, 0);
        inst_i = I_ADD; pc_i = 32'h104; fwdata_set();
        #1;
        check("haz_req", stallreq_o, 1);
        step();
        check("haz_bubble_wreg", ex_wreg_o, 0);
        check("haz_bubble_pc", ex_pc_o, 0);
        check("haz_inv", ex_inv_inst_o, 0);
        check("haz_cnt", stall_cnt_o, 1);
        ex_is_load_i = 0;
        #1;
        check("haz_clear", stallreq_o, 0);
        step();
        check("add_aluop", ex_aluop_o, 8'h20);
        check("add_wd", ex_wd_o, 8);
        check("add_fwd", ex_reg1_o, 64'h7777);
        check("add_pc", ex_pc_o, 32'h104);
        check("add_cnt", stall_cnt_o, 1);
        inst_i = I_ORI; pc_i = 32'h200; step();
        inst_i = I_ADD; ex_is_load_i = 1; stall_i = 1; step();
        check("stallhaz_hold", ex_pc_o, 32'h200);
        check("stallhaz_wd", ex_wd_o, 2);
        check("stallhaz_cnt", stall_cnt_o, 2);
        flush_i = 1; step();
        check("flushstall_wreg", ex_wreg_o, 0);
        check("flushstall_pc", ex_pc_o, 0);
        check("sat_cnt3", stall_cnt_o, 3);
        flush_i = 0; stall_i = 0;
        repeat (3) step();
        check("sat_hold", stall_cnt_o, 3);
        ex_is_load_i = 0; inst_i = I_ORI; pc_i = 32'h300; step();
        check("pre_rst_pc", ex_pc_o, 32'h300);
        stall_i = 1; inst_i = I_ADDI; step();
        check("held_pc", ex_pc_o, 32'h300);
        rst = 1; step();
        check("rst_stall_pc", ex_pc_o, 0);
        check("rst_stall_wreg", ex_wreg_o, 0);
        check("rst_stall_cnt", stall_cnt_o, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic fwdata_set();
        fwd_wdata_i = {64'h0, 64'h7777};
        reg2_data_i = 64'h9999;
    endtask
endmodule
